// File: rtl/dram_ras_cas_ctrl_pkg.sv
// Shared definitions for the VG8020 DRAM nRAS/nCAS/MUX controller.
package dram_pkg;

   localparam int unsigned NBANKS_MAX = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROW,
      ST_COL,
      ST_CAS,
      ST_PRE,
      ST_RFSH
   } state_t;

   // Counter holds a load value of (T - 1), so log2 of the largest T suffices.
   function automatic int unsigned cnt_width(input int unsigned max_t);
      int unsigned w;
      w = $clog2(max_t);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/dram_ras_cas_ctrl_sync_chain.sv
// Reset-to-1 synchroniser chain for active-low control bundles; STAGES=0 is a pass-through.
module sync_chain #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_nreset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (STAGES == 0) begin : g_pass
         assign o_q = i_d;
      end else begin : g_sync
         logic [WIDTH-1:0] r_stage [STAGES];

         always_ff @(posedge i_clk or negedge i_nreset) begin
            if (!i_nreset) begin
               for (int unsigned i = 0; i < STAGES; i++) r_stage[i] <= '1;
            end else begin
               r_stage[0] <= i_d;
               for (int unsigned i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
            end
         end

         assign o_q = r_stage[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/dram_ras_cas_ctrl.sv
// Clocked nRAS -> MUX -> nCAS sequencer with RAS-only refresh and enforced precharge.
module dram_ras_cas_ctrl
   import dram_pkg::*;
#(
   parameter int unsigned NBANKS      = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned T_RAS_MUX   = 1,
   parameter int unsigned T_MUX_CAS   = 1,
   parameter int unsigned T_RP        = 2,
   parameter int unsigned T_RFSH      = 3
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              nmreq,
   input  logic              nrfsh,
   input  logic [NBANKS-1:0] nsel,
   output logic [NBANKS-1:0] nras,
   output logic [NBANKS-1:0] ncas,
   output logic              mux,
   output logic              busy
);

   localparam int unsigned TMAX_A = (T_RAS_MUX > T_MUX_CAS) ? T_RAS_MUX : T_MUX_CAS;
   localparam int unsigned TMAX_B = (T_RP > T_RFSH) ? T_RP : T_RFSH;
   localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int unsigned CW     = cnt_width(TMAX);
   localparam int unsigned BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1;

   localparam logic [CW-1:0] LD_RAS_MUX = CW'(T_RAS_MUX - 1);
   localparam logic [CW-1:0] LD_MUX_CAS = CW'(T_MUX_CAS - 1);
   localparam logic [CW-1:0] LD_RP      = CW'(T_RP - 1);
   localparam logic [CW-1:0] LD_RFSH    = CW'(T_RFSH - 1);

   logic [NBANKS+1:0] w_sync_in;
   logic [NBANKS+1:0] w_sync_out;
   logic              w_s_nmreq;
   logic              w_s_nrfsh;
   logic [NBANKS-1:0] w_s_nsel;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [BW-1:0]     r_bank;
   logic [BW-1:0]     w_bank_nxt;
   logic              w_sel_any;
   logic [BW-1:0]     w_sel_idx;

   logic [NBANKS-1:0] w_nras_nxt;
   logic [NBANKS-1:0] w_ncas_nxt;
   logic              w_mux_nxt;
   logic              w_busy_nxt;

   assign w_sync_in = {nmreq, nrfsh, nsel};

   sync_chain #(
      .WIDTH  (NBANKS + 2),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk    (clk),
      .i_nreset (nreset),
      .i_d      (w_sync_in),
      .o_q      (w_sync_out)
   );

   assign w_s_nmreq = w_sync_out[NBANKS+1];
   assign w_s_nrfsh = w_sync_out[NBANKS];
   assign w_s_nsel  = w_sync_out[NBANKS-1:0];

   // Scan downwards so the lowest selected index is the one left standing.
   always_comb begin
      w_sel_any = 1'b0;
      w_sel_idx = '0;
      for (int unsigned i = NBANKS; i > 0; i--) begin
         if (!w_s_nsel[i-1]) begin
            w_sel_any = 1'b1;
            w_sel_idx = BW'(i - 1);
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bank  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bank  <= w_bank_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bank_nxt  = r_bank;
      w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (!w_s_nmreq && !w_s_nrfsh) begin
               w_state_nxt = ST_RFSH;
               w_cnt_nxt   = LD_RFSH;
            end else if (!w_s_nmreq && w_sel_any) begin
               w_state_nxt = ST_ROW;
               w_bank_nxt  = w_sel_idx;
               w_cnt_nxt   = LD_RAS_MUX;
            end
         end
         ST_ROW: begin
            if (w_s_nmreq) begin
               w_state_nxt = ST_PRE;
               w_cnt_nxt   = LD_RP;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_COL;
               w_cnt_nxt   = LD_MUX_CAS;
            end
         end
         ST_COL: begin
            if (w_s_nmreq) begin
               w_state_nxt = ST_PRE;
               w_cnt_nxt   = LD_RP;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_CAS;
            end
         end
         ST_CAS: begin
            if (w_s_nmreq) begin
               w_state_nxt = ST_PRE;
               w_cnt_nxt   = LD_RP;
            end
         end
         ST_PRE: begin
            if (r_cnt == '0) w_state_nxt = ST_IDLE;
         end
         ST_RFSH: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_PRE;
               w_cnt_nxt   = LD_RP;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from the next state and registered, so they move with the state flops.
   always_comb begin
      w_nras_nxt = '1;
      w_ncas_nxt = '1;
      w_mux_nxt  = 1'b0;
      w_busy_nxt = (w_state_nxt != ST_IDLE);
      case (w_state_nxt)
         ST_ROW:  w_nras_nxt[w_bank_nxt] = 1'b0;
         ST_COL: begin
            w_nras_nxt[w_bank_nxt] = 1'b0;
            w_mux_nxt              = 1'b1;
         end
         ST_CAS: begin
            w_nras_nxt[w_bank_nxt] = 1'b0;
            w_ncas_nxt[w_bank_nxt] = 1'b0;
            w_mux_nxt              = 1'b1;
         end
         ST_RFSH: w_nras_nxt = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         nras <= '1;
         ncas <= '1;
         mux  <= 1'b0;
         busy <= 1'b0;
      end else begin
         nras <= w_nras_nxt;
         ncas <= w_ncas_nxt;
         mux  <= w_mux_nxt;
         busy <= w_busy_nxt;
      end
   end

endmodule
